// File: rtl/rx_buffer_ctrl.sv
// UART receive buffer: captures one byte per receiver handshake into a
// first-word-fall-through FIFO and keeps overflow / parity-error statistics.
module rx_buffer_ctrl #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          rx_receive,
  input  logic [7:0]    rx_dout,
  input  logic          rx_perr,
  output logic          rx_received,
  output logic          out_valid,
  output logic [7:0]    out_data,
  output logic          out_perr,
  input  logic          out_ready,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic [7:0]    perr_count,
  input  logic          clear_stats
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, ACK} state_t;

  state_t        state, next_state;
  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          capture, pop, full, wr_en, drop, perr_hit;

  // Capture happens only on the IDLE->ACK transition, so a long request yields one byte
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (rx_receive) begin
          capture    = 1'b1;
          next_state = ACK;
        end
      end
      ACK: begin
        if (!rx_receive) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign full      = (count == CW'(DEPTH));
  assign wr_en     = capture & (~full | pop);
  assign drop      = capture & full & ~pop;
  assign perr_hit  = capture & rx_perr;
  assign out_data  = mem[rd_ptr][7:0];
  assign out_perr  = mem[rd_ptr][8];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      rx_received <= 1'b0;
    end else begin
      state       <= next_state;
      rx_received <= (next_state == ACK);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {rx_perr, rx_dout};
  end

  // Power-of-two depth lets the pointers wrap naturally
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A clear coincident with a new event leaves that event counted
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow   <= 1'b0;
      perr_count <= '0;
    end else if (clear_stats) begin
      overflow   <= drop;
      perr_count <= {7'b0, perr_hit};
    end else begin
      if (drop) overflow <= 1'b1;
      if (perr_hit && perr_count != 8'hFF) perr_count <= perr_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_rx_buffer_ctrl.sv
// Directed testbench for rx_buffer_ctrl: handshake, FIFO order, overflow,
// parity statistics, pointer wrap and mid-handshake reset.
module tb_rx_buffer_ctrl;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset_n, rx_receive, rx_perr, out_ready, clear_stats;
  logic [7:0]    rx_dout;
  logic          rx_received, out_valid, out_perr, overflow;
  logic [7:0]    out_data, perr_count;
  logic [CW-1:0] count;

  int total_cnt  = 0;
  int passed_cnt = 0;

  rx_buffer_ctrl #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .reset_n(reset_n), .rx_receive(rx_receive), .rx_dout(rx_dout),
    .rx_perr(rx_perr), .rx_received(rx_received), .out_valid(out_valid),
    .out_data(out_data), .out_perr(out_perr), .out_ready(out_ready),
    .count(count), .overflow(overflow), .perr_count(perr_count),
    .clear_stats(clear_stats)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset_n     = 1'b0;
    rx_receive  = 1'b0;
    rx_dout     = 8'h00;
    rx_perr     = 1'b0;
    out_ready   = 1'b0;
    clear_stats = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic p, output logic ack);
    rx_dout    = d;
    rx_perr    = p;
    rx_receive = 1'b1;
    tick();
    ack        = rx_received;
    rx_receive = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    do_reset();
    total_cnt++; if (rx_received !== 1'b0) $display("[TB] FAIL reset_ack: got %b want 0", rx_received); else passed_cnt++;
    total_cnt++; if (count !== '0) $display("[TB] FAIL reset_count: got %0d want 0", count); else passed_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b want 0", out_valid); else passed_cnt++;
    total_cnt++; if (overflow !== 1'b0) $display("[TB] FAIL reset_ovf: got %b want 0", overflow); else passed_cnt++;
    total_cnt++; if (perr_count !== 8'd0) $display("[TB] FAIL reset_perr: got %0d want 0", perr_count); else passed_cnt++;
  endtask

  task automatic test_single_byte;
    do_reset();
    rx_dout    = 8'hA5;
    rx_perr    = 1'b0;
    rx_receive = 1'b1;
    tick();
    total_cnt++; if (rx_received !== 1'b1) $display("[TB] FAIL single_ack1: got %b want 1", rx_received); else passed_cnt++;
    total_cnt++; if (count !== CW'(1)) $display("[TB] FAIL single_count1: got %0d want 1", count); else passed_cnt++;
    total_cnt++; if (out_data !== 8'hA5) $display("[TB] FAIL single_data: got %h want a5", out_data); else passed_cnt++;
    tick();
    tick();
    total_cnt++; if (rx_received !== 1'b1) $display("[TB] FAIL single_ack3: got %b want 1", rx_received); else passed_cnt++;
    total_cnt++; if (count !== CW'(1)) $display("[TB] FAIL single_once: got %0d want 1", count); else passed_cnt++;
    rx_receive = 1'b0;
    tick();
    total_cnt++; if (rx_received !== 1'b0) $display("[TB] FAIL single_ack_drop: got %b want 0", rx_received); else passed_cnt++;
    total_cnt++; if (out_perr !== 1'b0) $display("[TB] FAIL single_perr: got %b want 0", out_perr); else passed_cnt++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total_cnt++; if (out_valid !== 1'b0) $display("[TB] FAIL single_drain: got %b want 0", out_valid); else passed_cnt++;
  endtask

  task automatic test_fill_overflow;
    logic ack;
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      send_byte(8'(i), 1'b0, ack);
      total_cnt++; if (ack !== 1'b1) $display("[TB] FAIL fill_ack%0d: got %b want 1", i, ack); else passed_cnt++;
    end
    total_cnt++; if (count !== CW'(8)) $display("[TB] FAIL fill_count: got %0d want 8", count); else passed_cnt++;
    total_cnt++; if (overflow !== 1'b1) $display("[TB] FAIL fill_ovf: got %b want 1", overflow); else passed_cnt++;
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    total_cnt++; if (overflow !== 1'b0) $display("[TB] FAIL fill_clear: got %b want 0", overflow); else passed_cnt++;
    rx_dout     = 8'h0A;
    rx_receive  = 1'b1;
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    rx_receive  = 1'b0;
    tick();
    total_cnt++; if (overflow !== 1'b1) $display("[TB] FAIL fill_clear_drop: got %b want 1", overflow); else passed_cnt++;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      total_cnt++; if (out_data !== 8'(i)) $display("[TB] FAIL fill_drain%0d: got %h want %h", i, out_data, 8'(i)); else passed_cnt++;
      tick();
    end
    out_ready = 1'b0;
    total_cnt++; if (out_valid !== 1'b0) $display("[TB] FAIL fill_empty: got %b want 0", out_valid); else passed_cnt++;
  endtask

  task automatic test_full_pop;
    logic ack;
    logic [7:0] exp_q [$];
    do_reset();
    for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), 1'b0, ack);
    total_cnt++; if (count !== CW'(8)) $display("[TB] FAIL fullpop_pre: got %0d want 8", count); else passed_cnt++;
    rx_dout    = 8'h55;
    rx_receive = 1'b1;
    out_ready  = 1'b1;
    tick();
    out_ready  = 1'b0;
    total_cnt++; if (count !== CW'(8)) $display("[TB] FAIL fullpop_count: got %0d want 8", count); else passed_cnt++;
    total_cnt++; if (overflow !== 1'b0) $display("[TB] FAIL fullpop_ovf: got %b want 0", overflow); else passed_cnt++;
    rx_receive = 1'b0;
    tick();
    for (int i = 1; i < 8; i++) exp_q.push_back(8'h10 + 8'(i));
    exp_q.push_back(8'h55);
    out_ready = 1'b1;
    foreach (exp_q[i]) begin
      total_cnt++; if (out_data !== exp_q[i]) $display("[TB] FAIL fullpop_drain%0d: got %h want %h", i, out_data, exp_q[i]); else passed_cnt++;
      tick();
    end
    out_ready = 1'b0;
    total_cnt++; if (out_valid !== 1'b0) $display("[TB] FAIL fullpop_empty: got %b want 0", out_valid); else passed_cnt++;
  endtask

  task automatic test_parity_stats;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      rx_dout    = 8'(i);
      rx_perr    = 1'b1;
      rx_receive = 1'b1;
      tick();
      total_cnt++; if (out_perr !== 1'b1 || out_valid !== 1'b1) $display("[TB] FAIL parity_flag%0d: got %b/%b want 1/1", i, out_valid, out_perr); else passed_cnt++;
      rx_receive = 1'b0;
      tick();
    end
    total_cnt++; if (perr_count !== 8'd255) $display("[TB] FAIL parity_sat: got %0d want 255", perr_count); else passed_cnt++;
    rx_receive  = 1'b1;
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    rx_receive  = 1'b0;
    total_cnt++; if (perr_count !== 8'd1) $display("[TB] FAIL parity_clear: got %0d want 1", perr_count); else passed_cnt++;
    tick();
    rx_perr   = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_wrap;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rx_dout    = 8'h30 + 8'(i);
      rx_receive = 1'b1;
      tick();
      total_cnt++; if (count !== CW'(1) || out_data !== 8'h30 + 8'(i)) $display("[TB] FAIL wrap%0d: got %0d/%h want 1/%h", i, count, out_data, 8'h30 + 8'(i)); else passed_cnt++;
      rx_receive = 1'b0;
      tick();
      total_cnt++; if (count !== '0) $display("[TB] FAIL wrap_pop%0d: got %0d want 0", i, count); else passed_cnt++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic ack;
    do_reset();
    for (int i = 0; i < 3; i++) send_byte(8'h60 + 8'(i), 1'b0, ack);
    rx_dout    = 8'h77;
    rx_receive = 1'b1;
    tick();
    total_cnt++; if (count !== CW'(4) || rx_received !== 1'b1) $display("[TB] FAIL mid_pre: got %0d/%b want 4/1", count, rx_received); else passed_cnt++;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    total_cnt++; if (count !== '0) $display("[TB] FAIL mid_count: got %0d want 0", count); else passed_cnt++;
    total_cnt++; if (rx_received !== 1'b0) $display("[TB] FAIL mid_ack: got %b want 0", rx_received); else passed_cnt++;
    tick();
    total_cnt++; if (count !== CW'(1) || rx_received !== 1'b1) $display("[TB] FAIL mid_recap: got %0d/%b want 1/1", count, rx_received); else passed_cnt++;
    total_cnt++; if (out_data !== 8'h77) $display("[TB] FAIL mid_data: got %h want 77", out_data); else passed_cnt++;
    tick();
    rx_receive = 1'b0;
    tick();
    total_cnt++; if (count !== CW'(1) || rx_received !== 1'b0) $display("[TB] FAIL mid_once: got %0d/%b want 1/0", count, rx_received); else passed_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_fill_overflow();
    test_full_pop();
    test_parity_stats();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/rx_buffer_ctrl.md
RX_BUFFER_CTRL -- requirements
Module: rx_buffer_ctrl

Interface
REQ-001 The block SHALL have the following parameters, one per line:
- DEPTH, 8, FIFO entries; power of two, >= 2.
- CW, $clog2(DEPTH)+1, occupancy counter width.

REQ-002 The block SHALL have the following ports, one per line:
- clk  in  1  system clock; sole clock.
- reset_n  in  1  synchronous reset, active-low.
- rx_receive  in  1  byte-ready request from the UART receiver.
- rx_dout  in  8  received byte; valid while rx_receive=1.
- rx_perr  in  1  parity error for rx_dout; valid while rx_receive=1.
- rx_received  out  1  acknowledge to the UART receiver.
- out_valid  out  1  FIFO head valid.
- out_data  out  8  FIFO head byte.
- out_perr  out  1  FIFO head parity flag.
- out_ready  in  1  consumer accepts head.
- count  out  CW  FIFO occupancy, 0..DEPTH.
- overflow  out  1  sticky: a byte was dropped.
- perr_count  out  8  saturating count of parity-errored bytes.
- clear_stats  in  1  clears overflow and perr_count.

Function
REQ-003 The receiver handshake SHALL use a two-state FSM with states IDLE and ACK.
REQ-004 In IDLE with rx_receive=1, the block SHALL sample {rx_perr, rx_dout} once, enter ACK, and drive rx_received=1 from the next cycle.
REQ-005 In ACK, rx_received SHALL stay 1 until rx_receive=0 is sampled; the FSM SHALL then enter IDLE, with rx_received=0 on the following cycle.
REQ-006 Exactly one byte SHALL be captured per rx_receive high period, regardless of its length.
REQ-007 A capture SHALL write the FIFO when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
REQ-008 Otherwise the byte SHALL be dropped and overflow set to 1. The handshake SHALL still complete normally, so the receiver never stalls.
REQ-009 The FIFO SHALL be first-word-fall-through:
- out_valid = (count!=0).
- out_data and out_perr reflect the head entry combinationally from registered storage.
REQ-010 A pop SHALL occur when out_valid & out_ready. The read pointer SHALL advance by one and wrap from DEPTH-1 to 0.
REQ-011 The write pointer SHALL wrap from DEPTH-1 to 0.
REQ-012 A write SHALL become visible at out_* one cycle after capture. An empty FIFO SHALL NOT bypass.
REQ-013 count SHALL update as follows:
- +1 on write only.
- -1 on pop only.
- Unchanged on simultaneous write and pop, including at full.
REQ-014 out_ready while out_valid=0 SHALL have no effect.
REQ-015 perr_count SHALL increment on each captured byte with rx_perr=1, whether written or dropped, and saturate at 255.
REQ-016 clear_stats=1 SHALL zero overflow and perr_count. A drop or perr event in the same cycle SHALL take effect after the clear: overflow=1, perr_count=1.
REQ-017 All outputs except out_valid, out_data and out_perr SHALL be registered.

Reset
REQ-018 When reset_n=0 at a clock edge, the block SHALL set the following on the next cycle:
- FSM=IDLE, rx_received=0.
- Both pointers and count = 0, so out_valid=0.
- overflow=0, perr_count=0.
REQ-019 FIFO storage contents need not be reset, and out_data/out_perr are don't-care while out_valid=0.
REQ-020 Reset mid-handshake SHALL abort the handshake and discard all buffered bytes. If rx_receive is still 1 after reset deasserts, it SHALL be treated as a new request and captured.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- Single byte: rx_receive=1 with 0xA5, perr=0, held 3 cycles, out_ready=0 -> rx_received=1 from cycle+1 until one cycle after rx_receive falls; count=1; out_data=0xA5; exactly one capture.
- Fill/overflow: 9 handshakes (0x01..0x09) with out_ready=0 -> count=8; overflow=1; 0x09 dropped; every handshake acknowledged; draining yields 0x01..0x08 in order, then out_valid=0.
- Full with simultaneous pop: FIFO full, out_ready=1 during capture of 0x55 -> count stays 8; overflow=0; 0x55 emerges last.
- Parity stats: 300 bytes with rx_perr=1, out_ready=1 -> perr_count saturates at 255, out_perr=1 on each; clear_stats coincident with a perr byte -> perr_count=1.
- Wrap-around: 20 bytes streamed with out_ready=1 -> output order preserved across pointer wrap; count never exceeds 1.
- Reset mid-operation: 3 bytes buffered, ACK state, reset_n=0 for 1 cycle with rx_receive still 1 -> count=0, rx_received=0; after release the held byte is captured once, count=1.
